// File: rtl/argmax_classifier.sv
// Streaming argmax over OUTPUT_NUM unsigned class scores per frame; ties keep the lower index.
// Optional ARGMAX_SCORE_BUF_EN keeps the last completed frame's scores readable via rd_addr/rd_data.
module argmax_classifier #(
  parameter int OUTPUT_NUM = 10,
  parameter int SCORE_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [SCORE_BITS-1:0] data_in,
  input  logic                  flush,
`ifdef ARGMAX_SCORE_BUF_EN
  input  logic [3:0]            rd_addr,
  output logic [SCORE_BITS-1:0] rd_data,
`endif
  output logic [3:0]            class_out,
  output logic [SCORE_BITS-1:0] max_out,
  output logic                  valid_out,
  output logic                  busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(OUTPUT_NUM - 1);

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [SCORE_BITS-1:0] run_max_q, run_max_d;
  logic [3:0]            run_idx_q, run_idx_d;
  logic [3:0]            class_q, class_d;
  logic [SCORE_BITS-1:0] max_q, max_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [SCORE_BITS-1:0] new_max_s;
  logic [3:0]            new_idx_s;

  // Next-state, running-max and result update; flush overrides any score in the same cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    class_d   = class_q;
    max_d     = max_q;
    valid_d   = 1'b0;
    new_max_s = run_max_q;
    new_idx_s = run_idx_q;
    if (data_in > run_max_q) begin
      new_max_s = data_in;
      new_idx_s = cnt_q;
    end else begin
      new_max_s = run_max_q;
      new_idx_s = run_idx_q;
    end
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (valid_in) begin
      case (state_q)
        ST_IDLE: begin
          run_max_d = data_in;
          run_idx_d = 4'd0;
          cnt_d     = 4'd1;
          state_d   = ST_ACCUM;
        end
        ST_ACCUM: begin
          run_max_d = new_max_s;
          run_idx_d = new_idx_s;
          if (cnt_q == LAST_IDX) begin
            class_d = new_idx_s;
            max_d   = new_max_s;
            valid_d = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == ST_ACCUM);
  end

  // Control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      run_max_q <= '0;
      run_idx_q <= 4'd0;
      class_q   <= 4'd0;
      max_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      class_q   <= class_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign class_out = class_q;
  assign max_out   = max_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;

`ifdef ARGMAX_SCORE_BUF_EN
  logic [SCORE_BITS-1:0] stage_q [OUTPUT_NUM];
  logic [SCORE_BITS-1:0] stage_d [OUTPUT_NUM];
  logic [SCORE_BITS-1:0] sbuf_q  [OUTPUT_NUM];
  logic [SCORE_BITS-1:0] sbuf_d  [OUTPUT_NUM];
  logic                  accept_s;

  assign accept_s = valid_in & ~flush;

  // Scores of the frame in flight are staged, then published together with the result
  always_comb begin
    stage_d = stage_q;
    sbuf_d  = sbuf_q;
    if (accept_s) begin
      stage_d[cnt_q] = data_in;
    end else begin
      stage_d = stage_q;
    end
    if (valid_d) begin
      sbuf_d = stage_d;
    end else begin
      sbuf_d = sbuf_q;
    end
  end

  // Staging and published score buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTPUT_NUM; i++) begin
        stage_q[i] <= '0;
        sbuf_q[i]  <= '0;
      end
    end else begin
      stage_q <= stage_d;
      sbuf_q  <= sbuf_d;
    end
  end

  // Combinational read port; addresses past the last class read as zero
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < 5'(OUTPUT_NUM)) begin
      rd_data = sbuf_q[rd_addr];
    end else begin
      rd_data = '0;
    end
  end
`endif

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter OUTPUT_NUM, default 10, number of class scores per frame (2..16).
REQ-002 Parameter SCORE_BITS, default 12, width of each unsigned class score.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  qualifies data_in; one score accepted per cycle when high.
REQ-006 data_in  input  SCORE_BITS  unsigned class score; arrives in class order 0..OUTPUT_NUM-1.
REQ-007 flush  input  1  synchronous abort of the frame in progress.
REQ-008 class_out  output  4  index of the winning class of the last completed frame.
REQ-009 max_out  output  SCORE_BITS  score of the winning class of the last completed frame.
REQ-010 valid_out  output  1  one-cycle pulse: class_out/max_out updated.
REQ-011 busy  output  1  high while a frame is partially received (state ACCUM).

Function
REQ-012 FSM states IDLE and ACCUM; score counter cnt (4 bits) counts scores accepted in the current frame.
REQ-013 IDLE + valid_in: run_max <= data_in, run_idx <= 0, cnt <= 1, go ACCUM; if OUTPUT_NUM==1 not supported.
REQ-014 ACCUM + valid_in: if data_in > run_max (strict, unsigned) then run_max <= data_in, run_idx <= cnt; cnt <= cnt+1.
REQ-015 Ties keep the earlier (lower) class index.
REQ-016 Score accepted with cnt == OUTPUT_NUM-1 completes the frame: next cycle valid_out=1, class_out/max_out hold the final winner including that score, FSM in IDLE, cnt=0.
REQ-017 Latency: valid_out asserts exactly 1 cycle after the last score's valid_in cycle.
REQ-018 class_out/max_out change only on the valid_out cycle; held stable otherwise, including during the next frame.
REQ-019 valid_in gaps (valid_in low) inside a frame are allowed; state and cnt hold.
REQ-020 valid_in in the cycle valid_out is high is accepted as score 0 of the next frame; back-to-back frames with no idle cycle are supported.
REQ-021 flush high: FSM -> IDLE, cnt <= 0, no valid_out for the aborted frame; result registers unchanged.
REQ-022 flush and valid_in in the same cycle: flush wins, that score is dropped.
REQ-023 flush in the cycle the last score arrives: flush wins, no valid_out.
REQ-024 busy = (state == ACCUM), registered.

Reset
REQ-025 rst_n low asynchronously forces IDLE, cnt=0, run_max=0, run_idx=0, class_out=0, max_out=0, valid_out=0, busy=0.
REQ-026 Reset mid-frame discards the partial frame; first valid_in after release is score 0.

Configuration
REQ-027 Macro ARGMAX_SCORE_BUF_EN defined: add ports rd_addr input 4 and rd_data output SCORE_BITS; all OUTPUT_NUM scores of the last completed frame are latched into a buffer on the valid_out cycle; rd_data = buffer[rd_addr] combinationally, 0 for rd_addr >= OUTPUT_NUM; buffer resets to 0.
REQ-028 Macro undefined: no rd_addr/rd_data ports, no score buffer storage; all other behaviour identical.

Verification
REQ-029 Scores 5,9,3,12,7,1,0,2,11,4 on 10 consecutive cycles -> valid_out one cycle later, class_out=3, max_out=12, busy low after.
REQ-030 Scores all equal 100 -> class_out=0, max_out=100; max at last position (all 0 except index 9=4095) -> class_out=9, max_out=4095.
REQ-031 Same frame with valid_in low every other cycle -> identical result, valid_out 1 cycle after 10th score; two frames back-to-back -> two valid_out pulses 10 cycles apart with correct independent results.
REQ-032 flush after 6 scores, then fresh 10-score frame with max 50 at index 2 -> single valid_out, class_out=2, max_out=50; flush coincident with 10th score -> no valid_out.
REQ-033 rst_n pulsed low asynchronously (between edges) mid-frame -> outputs 0 immediately; subsequent full frame produces correct result; with ARGMAX_SCORE_BUF_EN, rd_addr 0..9 returns the frame's scores, rd_addr 12 returns 0.
